// File: rtl/demux_param_hs_if.sv
// demux_param_hs_if: bundles the producer stream and the N consumer lanes
// of demux_param_hs into one port. The slave modport is the demux itself;
// the master modport is whatever drives the producer side and consumes the
// lanes (a testbench, or glue logic that splits the lanes out again).
interface demux_param_hs_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    // Producer side
    logic [WIDTH-1:0]   in_data;
    logic [SELW-1:0]    in_sel;
    logic               in_valid;
    logic               in_ready;

    // Consumer lanes, lane k at bits [k*WIDTH +: WIDTH]
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;

    // Bad-select reporting
    logic               err_sel;
    logic [7:0]         err_cnt;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  err_sel,
        input  err_cnt
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output err_sel,
        output err_cnt
    );
endinterface

// File: rtl/demux_param_hs.sv
// demux_param_hs: 1-to-N demultiplexer with a single-entry holding register
// per output lane and valid/ready flow control on both sides.
//
// A word on the producer side is steered by in_sel into lane in_sel. Each
// lane is a two-state EMPTY/FULL stage; a full lane that is being drained
// can be reloaded in the same cycle, so back-to-back words to one lane flow
// without a bubble. A stalled lane only blocks words addressed to it.
//
// Words whose select is out of range (only possible when N is not a power
// of two) are always accepted and dropped, and err_sel pulses for the
// following cycle so the producer is never stalled by a bad select.
//
// Optional feature, macro DEMUX_ERRCNT_EN:
//   defined   - err_cnt is a saturating 8-bit count of dropped words,
//               cleared only by rst_n.
//   undefined - no counter is built and err_cnt is tied to zero.
module demux_param_hs #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_param_hs_if.slave     bus
);

    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } laneState_t;

    laneState_t         r_state     [N];
    laneState_t         w_nextState [N];
    logic [N*WIDTH-1:0] r_data;
    logic               r_errSel;

    logic [31:0]        w_selIdx;
    logic               w_selOk;
    logic               w_laneFree;
    logic               w_inReady;
    logic               w_accept;
    logic               w_badAccept;
    logic [N-1:0]       w_load;
    logic [N-1:0]       w_drain;
    logic [N-1:0]       w_full;

    // Decode the select and decide whether the addressed lane can take a word:
    // it must be empty or emptying this cycle. Out-of-range selects are
    // always ready so the bad word is swallowed instead of stalling.
    always_comb begin
        w_selIdx   = 32'(bus.in_sel);
        w_selOk    = (w_selIdx < 32'(N));
        w_laneFree = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (w_selIdx == 32'(k)) begin
                w_laneFree = (r_state[k] == EMPTY) || bus.out_ready[k];
            end
        end
        w_inReady   = w_laneFree;
        w_accept    = bus.in_valid && w_inReady;
        w_badAccept = w_accept && !w_selOk;
    end

    // Per-lane load and drain strobes derived from the handshakes.
    always_comb begin
        w_load  = '0;
        w_drain = '0;
        w_full  = '0;
        for (int k = 0; k < N; k++) begin
            w_full[k]  = (r_state[k] == FULL);
            w_drain[k] = w_full[k] && bus.out_ready[k];
            w_load[k]  = w_accept && w_selOk && (w_selIdx == 32'(k));
        end
    end

    // Lane FSM next state: a load always leaves the lane full (covering the
    // drain-and-reload case), a drain without a load empties it.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_nextState[k] = r_state[k];
            case (r_state[k])
                EMPTY: begin
                    if (w_load[k]) begin
                        w_nextState[k] = FULL;
                    end
                end
                FULL: begin
                    if (w_load[k]) begin
                        w_nextState[k] = FULL;
                    end else if (w_drain[k]) begin
                        w_nextState[k] = EMPTY;
                    end
                end
                default: w_nextState[k] = EMPTY;
            endcase
        end
    end

    // Lane FSM state register; reset empties every lane at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_state[k] <= EMPTY;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                r_state[k] <= w_nextState[k];
            end
        end
    end

    // Lane holding registers: written only on a load, left untouched on a
    // drain so the last word stays visible after the lane empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_load[k]) begin
                    r_data[k*WIDTH +: WIDTH] <= bus.in_data;
                end
            end
        end
    end

    // One-cycle error pulse following every dropped bad-select word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errSel <= 1'b0;
        end else begin
            r_errSel <= w_badAccept;
        end
    end

`ifdef DEMUX_ERRCNT_EN
    logic [7:0] r_errCnt;

    // Saturating count of dropped words; sticks at 255 until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt <= 8'd0;
        end else if (w_badAccept && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_errCnt;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_full;
    assign bus.out_data  = r_data;
    assign bus.err_sel   = r_errSel;

endmodule

// File: tb/tb_demux_param_hs.sv
// tb_demux_param_hs: directed self-checking bench for demux_param_hs.
// Uses an N=4 instance for lane behaviour and reset, and an N=3 instance
// for the out-of-range select path. Expected err_cnt follows DEMUX_ERRCNT_EN.
module tb_demux_param_hs;

`ifdef DEMUX_ERRCNT_EN
    localparam logic [7:0] EXP_ERRCNT = 8'd255;
`else
    localparam logic [7:0] EXP_ERRCNT = 8'd0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    demux_param_hs_if #(.WIDTH(8), .N(4)) bus4 ();
    demux_param_hs_if #(.WIDTH(8), .N(3)) bus3 ();

    demux_param_hs #(.WIDTH(8), .N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    demux_param_hs #(.WIDTH(8), .N(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] sel, input logic valid, input logic [3:0] ready);
        bus4.in_data   = data;
        bus4.in_sel    = sel;
        bus4.in_valid  = valid;
        bus4.out_ready = ready;
        #1;
    endtask

    // Main directed sequence.
    initial begin
        logic       modelFull [4];
        logic [7:0] modelData [4];
        logic [3:0] readyV;
        logic [1:0] selV;
        logic [7:0] dataV;
        logic       validV;
        logic       expReady;
        logic       done;
        int         sent;
        int         delivered;
        int         cycles;

        bus4.in_data   = '0;
        bus4.in_sel    = '0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = '0;
        bus3.in_data   = '0;
        bus3.in_sel    = '0;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = '0;

        // Reset state
        #12;
        checkOutput("rst out_valid", 32'(bus4.out_valid), 32'h0);
        checkOutput("rst out_data", bus4.out_data, 32'h0);
        checkOutput("rst err_sel", 32'(bus4.err_sel), 32'h0);
        checkOutput("rst err_cnt", 32'(bus4.err_cnt), 32'h0);
        checkOutput("rst in_ready", 32'(bus4.in_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word to lane 1, one cycle latency
        applyStimulus(8'h32, 2'd1, 1'b1, 4'b0000);
        checkOutput("t1 in_ready", 32'(bus4.in_ready), 32'h1);
        tick();
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("t1 out_valid", 32'(bus4.out_valid), 32'h2);
        checkOutput("t1 out_data", bus4.out_data, 32'h0000_3200);

        // Stalled lane 2 blocks only its own traffic
        applyStimulus(8'hA5, 2'd2, 1'b1, 4'b0000);
        tick();
        applyStimulus(8'h11, 2'd2, 1'b1, 4'b0000);
        checkOutput("t2 blocked in_ready", 32'(bus4.in_ready), 32'h0);
        tick();
        checkOutput("t2 lane2 held", 32'(bus4.out_data[23:16]), 32'hA5);
        applyStimulus(8'h22, 2'd0, 1'b1, 4'b0000);
        checkOutput("t2 lane0 in_ready", 32'(bus4.in_ready), 32'h1);
        tick();
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("t2 lane0 data", 32'(bus4.out_data[7:0]), 32'h22);
        checkOutput("t2 out_valid", 32'(bus4.out_valid), 32'h7);
        checkOutput("t2 lane2 still", 32'(bus4.out_data[23:16]), 32'hA5);

        // Drain and reload lane 3 in the same cycle, no bubble
        applyStimulus(8'h01, 2'd3, 1'b1, 4'b0000);
        tick();
        checkOutput("t3 out_valid full", 32'(bus4.out_valid), 32'hF);
        applyStimulus(8'h02, 2'd3, 1'b1, 4'b1000);
        checkOutput("t3 in_ready", 32'(bus4.in_ready), 32'h1);
        checkOutput("t3 first word", 32'(bus4.out_data[31:24]), 32'h01);
        tick();
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1000);
        checkOutput("t3 valid after reload", 32'(bus4.out_valid), 32'hF);
        checkOutput("t3 second word", 32'(bus4.out_data[31:24]), 32'h02);
        tick();
        checkOutput("t3 lane3 drained", 32'(bus4.out_valid), 32'h7);
        checkOutput("t3 data kept", 32'(bus4.out_data[31:24]), 32'h02);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111);
        tick();
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("t3 all drained", 32'(bus4.out_valid), 32'h0);

        // Bad select on the N=3 instance
        for (int i = 0; i < 300; i++) begin
            bus3.in_data  = 8'hFF;
            bus3.in_sel   = 2'd3;
            bus3.in_valid = 1'b1;
            #1;
            checkOutput("bad in_ready", 32'(bus3.in_ready), 32'h1);
            tick();
            checkOutput("bad err_sel", 32'(bus3.err_sel), 32'h1);
            checkOutput("bad out_valid", 32'(bus3.out_valid), 32'h0);
        end
        bus3.in_valid = 1'b0;
        tick();
        checkOutput("bad err_sel idle", 32'(bus3.err_sel), 32'h0);
        checkOutput("bad out_data", 32'(bus3.out_data), 32'h0);
        checkOutput("bad err_cnt", 32'(bus3.err_cnt), 32'(EXP_ERRCNT));

        // Random traffic against a per-lane model
        for (int k = 0; k < 4; k++) begin
            modelFull[k] = 1'b0;
            modelData[k] = 8'h00;
        end
        sent      = 0;
        delivered = 0;
        cycles    = 0;
        done      = 1'b0;
        while (!done && cycles < 20000) begin
            readyV = 4'($urandom_range(0, 15));
            selV   = 2'($urandom_range(0, 3));
            dataV  = 8'($urandom_range(0, 255));
            validV = (sent < 1000);
            if (!validV) begin
                readyV = 4'hF;
            end
            applyStimulus(dataV, selV, validV, readyV);
            for (int k = 0; k < 4; k++) begin
                checkOutput("rnd out_valid", 32'(bus4.out_valid[k]), 32'(modelFull[k]));
                if (modelFull[k]) begin
                    checkOutput("rnd out_data", 32'(bus4.out_data[k*8 +: 8]), 32'(modelData[k]));
                end
            end
            expReady = !modelFull[selV] || readyV[selV];
            checkOutput("rnd in_ready", 32'(bus4.in_ready), 32'(expReady));
            for (int k = 0; k < 4; k++) begin
                if (modelFull[k] && readyV[k]) begin
                    modelFull[k] = 1'b0;
                    delivered++;
                end
            end
            if (validV && expReady) begin
                modelFull[selV] = 1'b1;
                modelData[selV] = dataV;
                sent++;
            end
            tick();
            cycles++;
            done = (sent == 1000) && !modelFull[0] && !modelFull[1] && !modelFull[2] && !modelFull[3];
        end
        checkOutput("rnd finished", 32'(done), 32'h1);
        checkOutput("rnd delivered", 32'(delivered), 32'd1000);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("rnd empty", 32'(bus4.out_valid), 32'h0);

        // Reset in the middle of a transfer
        applyStimulus(8'hAA, 2'd0, 1'b1, 4'b0000);
        tick();
        applyStimulus(8'hBB, 2'd2, 1'b1, 4'b0000);
        tick();
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("mid loaded", 32'(bus4.out_valid), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid out_valid", 32'(bus4.out_valid), 32'h0);
        checkOutput("mid out_data", bus4.out_data, 32'h0);
        checkOutput("mid err_cnt", 32'(bus4.err_cnt), 32'h0);
        checkOutput("mid err_cnt n3", 32'(bus3.err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(8'h5C, 2'd2, 1'b1, 4'b0000);
        checkOutput("post in_ready", 32'(bus4.in_ready), 32'h1);
        tick();
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("post out_valid", 32'(bus4.out_valid), 32'h4);
        checkOutput("post out_data", bus4.out_data, 32'h005C_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
